// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Responder end of a 4x4 matrix-keypad scan interface. It emulates a physical
//   keypad for a scanning controller. A key-press request is taken over a
//   valid/ready handshake. The addressed contact is then closed for HOLD_CYCLES
//   clocks and opened for GAP_CYCLES clocks. While the contact is closed, the
//   matching active-low row is pulled low whenever the scanner drives that
//   column low.
//
//   Optional feature macro: KEYPAD_EMU_BOUNCE_EN
//     When this macro is defined, contact bounce is emulated at make and at
//     break (states BOUNCE_MAKE and BOUNCE_BREAK). Each bounce state runs
//     BOUNCE_COUNT closed/open pairs of BOUNCE_CYCLES clocks each.
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  synchronous active-low reset (0 = reset)
//   key          in   4  requested key: [3:2] row index, [1:0] column index
//   press_valid  in   1  request strobe, accepted when press_ready is high
//   press_ready  out  1  high only while idle
//   columnN      in   4  scanner column drive, active-low
//   rowN         out  4  row return, active-low, 1 = released
//   pressed      out  1  contact currently closed
//   busy         out  1  high whenever not idle
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 50_000,
  parameter int GAP_CYCLES    = 50_000,
  parameter int BOUNCE_CYCLES = 500,
  parameter int BOUNCE_COUNT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic       press_valid,
  output logic       press_ready,
  input  logic [3:0] columnN,
  output logic [3:0] rowN,
  output logic       pressed,
  output logic       busy
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int PAIR_W = (BOUNCE_COUNT > 1) ? $clog2(BOUNCE_COUNT) : 1;
  localparam logic [CNT_W-1:0]  BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [PAIR_W-1:0] PAIR_LOAD   = PAIR_W'(BOUNCE_COUNT - 1);
  localparam logic [PAIR_W-1:0] PAIR_ONE    = PAIR_W'(1);

  typedef enum logic [2:0] {IDLE, HOLD, GAP, BOUNCE_MAKE, BOUNCE_BREAK} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  // BOUNCE_COUNT only shapes bounce emulation; here it is deliberately sunk.
  logic unused_bounce_count;
  assign unused_bounce_count = ^32'(BOUNCE_COUNT);
`endif

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       key_q, key_next;
  logic             pressed_next, busy_next;
  logic [3:0]       col_meta, col_s;
  logic             closed_d1, closed_d2;
  logic [3:0]       row_next;

`ifdef KEYPAD_EMU_BOUNCE_EN
  // phase: 0 = first half of a bounce pair, 1 = second half.
  logic              phase, phase_next;
  logic [PAIR_W-1:0] pair, pair_next;
`endif

  assign press_ready = (state == IDLE);

  // Next-state logic for the press sequencer.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    key_next   = key_q;
`ifdef KEYPAD_EMU_BOUNCE_EN
    phase_next = phase;
    pair_next  = pair;
`endif
    case (state)
      IDLE: begin
        if (press_valid) begin
          key_next = key;
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_next = BOUNCE_MAKE;
          cnt_next   = BOUNCE_LOAD;
          phase_next = 1'b0;
          pair_next  = PAIR_LOAD;
`else
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
`endif
        end
      end
      HOLD: begin
        if (cnt == '0) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_next = BOUNCE_BREAK;
          cnt_next   = BOUNCE_LOAD;
          phase_next = 1'b0;
          pair_next  = PAIR_LOAD;
`else
          state_next = GAP;
          cnt_next   = GAP_LOAD;
`endif
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      BOUNCE_MAKE, BOUNCE_BREAK: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_ONE;
        end else if (!phase) begin
          cnt_next   = BOUNCE_LOAD;
          phase_next = 1'b1;
        end else if (pair != '0) begin
          cnt_next   = BOUNCE_LOAD;
          phase_next = 1'b0;
          pair_next  = pair - PAIR_ONE;
        end else begin
          phase_next = 1'b0;
          if (state == BOUNCE_MAKE) begin
            state_next = HOLD;
            cnt_next   = HOLD_LOAD;
          end else begin
            state_next = GAP;
            cnt_next   = GAP_LOAD;
          end
        end
      end
`endif
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Contact state follows the next state so that pressed/busy are registered
  // alongside it. Make bounce starts closed; break bounce starts open.
  always_comb begin
    pressed_next = 1'b0;
    case (state_next)
      HOLD:         pressed_next = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
      BOUNCE_MAKE:  pressed_next = !phase_next;
      BOUNCE_BREAK: pressed_next = phase_next;
`endif
      default:      pressed_next = 1'b0;
    endcase
    busy_next = (state_next != IDLE);
  end

  // The contact state is delayed by two stages to line up with the column
  // synchronizer, so that rowN follows both inputs with the same latency.
  always_comb begin
    row_next = 4'hF;
    if (closed_d2 && !col_s[key_q[1:0]]) begin
      row_next[key_q[3:2]] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      key_q     <= 4'h0;
      pressed   <= 1'b0;
      busy      <= 1'b0;
      col_meta  <= 4'hF;
      col_s     <= 4'hF;
      closed_d1 <= 1'b0;
      closed_d2 <= 1'b0;
      rowN      <= 4'hF;
`ifdef KEYPAD_EMU_BOUNCE_EN
      phase     <= 1'b0;
      pair      <= '0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      key_q     <= key_next;
      pressed   <= pressed_next;
      busy      <= busy_next;
      col_meta  <= columnN;
      col_s     <= col_meta;
      closed_d1 <= pressed;
      closed_d2 <= closed_d1;
      rowN      <= row_next;
`ifdef KEYPAD_EMU_BOUNCE_EN
      phase     <= phase_next;
      pair      <= pair_next;
`endif
    end
  end

endmodule
